// File: rtl/i2s_rx.sv
// I2S receive deserializer: oversamples lrck/sck/sdin on clk and recovers one
// left/right pair per frame, strobing valid when a complete pair is available.
module i2s_rx #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lrck,
    input  logic             sck,
    input  logic             sdin,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right,
    output logic             valid,
    output logic             err
);

    localparam logic [5:0] BITS = 6'(WIDTH);

    // Pin order in the synchronizer vector: 0 = lrck, 1 = sck, 2 = sdin.
    logic [2:0] pins;
    logic [2:0] sync_s2;
    logic       sck_s3_reg;

    assign pins = {sdin, sck, lrck};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= pins[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign sync_s2[gi] = s2_reg;
        end
    endgenerate

    logic lrck_s2;
    logic sck_s2;
    logic sdin_s2;
    logic sck_rise;

    assign lrck_s2  = sync_s2[0];
    assign sck_s2   = sync_s2[1];
    assign sdin_s2  = sync_s2[2];
    assign sck_rise = sck_s2 & ~sck_s3_reg;

    logic [WIDTH-1:0] shreg_reg,     shreg_next;
    logic [WIDTH-1:0] left_hold_reg, left_hold_next;
    logic [WIDTH-1:0] left_reg,      left_next;
    logic [WIDTH-1:0] right_reg,     right_next;
    logic [5:0]       bitcnt_reg,    bitcnt_next;
    logic             lr_q_reg,      lr_q_next;
    logic             chan_reg,      chan_next;
    logic             armed_reg,     armed_next;
    logic             have_left_reg, have_left_next;
    logic             valid_reg,     valid_next;
    logic             err_reg,       err_next;
    logic [WIDTH-1:0] word;

    assign word = {shreg_reg[WIDTH-2:0], sdin_s2};

    always_comb begin
        shreg_next     = shreg_reg;
        left_hold_next = left_hold_reg;
        left_next      = left_reg;
        right_next     = right_reg;
        bitcnt_next    = bitcnt_reg;
        lr_q_next      = lr_q_reg;
        chan_next      = chan_reg;
        armed_next     = armed_reg;
        have_left_next = have_left_reg;
        valid_next     = 1'b0;
        err_next       = 1'b0;

        if (sck_rise) begin
            lr_q_next = lrck_s2;
            if (lrck_s2 != lr_q_reg) begin
                // Slot start: the bit on this rise belongs to the previous slot.
                if (armed_reg && bitcnt_reg != 6'd0 && bitcnt_reg < BITS)
                    err_next = 1'b1;
                bitcnt_next = 6'd0;
                chan_next   = lrck_s2;
                shreg_next  = '0;
                if (!lrck_s2)
                    armed_next = 1'b1;
            end else if (bitcnt_reg < BITS) begin
                shreg_next  = word;
                bitcnt_next = bitcnt_reg + 6'd1;
                if (bitcnt_reg == BITS - 6'd1 && armed_reg) begin
                    if (!chan_reg) begin
                        left_hold_next = word;
                        have_left_next = 1'b1;
                    end else if (have_left_reg) begin
                        left_next      = left_hold_reg;
                        right_next     = word;
                        valid_next     = 1'b1;
                        have_left_next = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_s3_reg    <= 1'b0;
            shreg_reg     <= '0;
            left_hold_reg <= '0;
            left_reg      <= '0;
            right_reg     <= '0;
            bitcnt_reg    <= 6'd0;
            lr_q_reg      <= 1'b1;
            chan_reg      <= 1'b0;
            armed_reg     <= 1'b0;
            have_left_reg <= 1'b0;
            valid_reg     <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            sck_s3_reg    <= sck_s2;
            shreg_reg     <= shreg_next;
            left_hold_reg <= left_hold_next;
            left_reg      <= left_next;
            right_reg     <= right_next;
            bitcnt_reg    <= bitcnt_next;
            lr_q_reg      <= lr_q_next;
            chan_reg      <= chan_next;
            armed_reg     <= armed_next;
            have_left_reg <= have_left_next;
            valid_reg     <= valid_next;
            err_reg       <= err_next;
        end
    end

    assign left  = left_reg;
    assign right = right_reg;
    assign valid = valid_reg;
    assign err   = err_reg;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed and randomized I2S frames checked cycle by cycle against a
// slot-level model of which words, valid pulses and err pulses should appear.
module tb_i2s_rx;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         lrck;
    logic         sck;
    logic         sdin;
    logic [W-1:0] left;
    logic [W-1:0] right;
    logic         valid;
    logic         err;

    int n_vec = 0;
    int n_err = 0;

    // Slot-level model state
    logic         m_armed;
    logic         m_have;
    logic         m_lrq;
    logic [W-1:0] m_hold;
    logic [W-1:0] m_left;
    logic [W-1:0] m_right;
    int           m_bits;

    i2s_rx #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .lrck  (lrck),
        .sck   (sck),
        .sdin  (sdin),
        .left  (left),
        .right (right),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input logic ev_v, input logic ev_e);
        chk("valid", 32'(valid), 32'(ev_v));
        chk("err",   32'(err),   32'(ev_e));
        chk("left",  32'(left),  32'(m_left));
        chk("right", 32'(right), 32'(m_right));
    endtask

    task automatic model_reset();
        m_armed = 1'b0;
        m_have  = 1'b0;
        m_lrq   = 1'b1;
        m_hold  = '0;
        m_left  = '0;
        m_right = '0;
        m_bits  = 0;
    endtask

    // One lrck slot of nper sck periods. The first rstp periods are held in
    // reset with random pins (only used with lr = 1). abort_at >= 0 asserts
    // reset at the start of that period and ends the slot there.
    task automatic send_slot(input logic lr, input logic [W-1:0] w, input int nper,
                             input int rstp, input int abort_at);
        logic start;
        logic ev_err;
        logic complete;
        logic ev_v;
        logic ev_e;
        if (rstp > 0)
            model_reset();
        start  = (rstp == 0) && (lr != m_lrq);
        ev_err = start && m_armed && m_bits > 0 && m_bits < W;
        if (start && !lr)
            m_armed = 1'b1;
        complete = start && m_armed && (nper - 1 >= W);

        for (int p = 0; p < nper; p++) begin
            @(negedge clk);
            sck = 1'b0;
            if (p == abort_at) begin
                rst = 1'b0;
                model_reset();
                #1;
                chk_all(1'b0, 1'b0);
                return;
            end
            rst  = (p < rstp) ? 1'b0 : 1'b1;
            lrck = (p < rstp) ? 1'($urandom) : lr;
            sdin = (start && p >= 1 && p <= W) ? w[W-p] : 1'($urandom);
            repeat (4) begin
                @(posedge clk);
                #1;
                chk_all(1'b0, 1'b0);
            end
            @(negedge clk);
            sck = 1'b1;
            for (int i = 0; i < 4; i++) begin
                ev_v = 1'b0;
                ev_e = 1'b0;
                @(posedge clk);
                #1;
                if (i == 2 && p >= rstp) begin
                    if (p == 0)
                        ev_e = ev_err;
                    if (p == W && complete) begin
                        if (!lr) begin
                            m_hold = w;
                            m_have = 1'b1;
                        end else if (m_have) begin
                            m_left  = m_hold;
                            m_right = w;
                            m_have  = 1'b0;
                            ev_v    = 1'b1;
                        end
                    end
                end
                chk_all(ev_v, ev_e);
            end
        end

        if (start)
            m_bits = (nper - 1 < W) ? nper - 1 : W;
        else
            m_bits = (m_bits + nper - rstp < W) ? m_bits + nper - rstp : W;
        if (rstp < nper)
            m_lrq = lr;
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                              input int nl, input int nr);
        send_slot(1'b0, l, nl, 0, -1);
        send_slot(1'b1, r, nr, 0, -1);
    endtask

    initial begin
        rst  = 1'b0;
        lrck = 1'b0;
        sck  = 1'b0;
        sdin = 1'b0;
        model_reset();
        #1;
        chk_all(1'b0, 1'b0);

        // Reset held while all pins toggle
        send_slot(1'b1, 24'h5A5A5A, 8, 8, -1);

        // Nominal frame
        send_frame(24'h123456, 24'hABCDEF, 32, 32);

        // Back-to-back frames with extreme values
        send_frame(24'h000001, 24'hFFFFFF, 32, 32);
        send_frame(24'h800000, 24'h7FFFFF, 32, 32);

        // Short right slot: err at the next slot start, no valid for that frame
        send_frame(24'h13579B, 24'h2468AC, 32, 10);
        send_frame(24'hC0FFEE, 24'h0BEEF0, 32, 32);

        // Randomized frames and slot lengths
        for (int f = 0; f < 6; f++)
            send_frame(W'($urandom), W'($urandom),
                       $urandom_range(32, 25), $urandom_range(32, 25));

        // Reset asserted during bit 12 of a left word, released mid right slot
        send_slot(1'b0, 24'h111111, 32, 0, 12);
        send_slot(1'b1, 24'h222222, 32, 4, -1);
        send_frame(24'h00AA55, 24'h55AA00, 32, 32);

        // Trailing left slot exposes any err left over from the last frame
        send_slot(1'b0, 24'h3C3C3C, 32, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
